// File: rtl/pif_ram_arb_pkg.sv
// Shared types and widths for the PIF RAM arbiter: FSM states, read owner tags
// and the PIF RAM geometry (512 words of 32 bits).
package pif_ram_arb_pkg;

  localparam int PIF_ADDR_W = 9;
  localparam int PIF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    LOCK_ERR = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_N64  = 2'd1,
    TAG_CPU  = 2'd2
  } owner_tag_e;

endpackage

// File: rtl/pif_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The slave side is the arbiter; the master side drives requests and RAM data.
interface pif_ram_arbiter_if;
  import pif_ram_arb_pkg::*;

  logic                  pif_disable;
  logic                  n64_req;
  logic                  n64_lock;
  logic                  n64_wren;
  logic [PIF_ADDR_W-1:0] n64_address;
  logic [PIF_DATA_W-1:0] n64_wdata;
  logic                  n64_gnt;
  logic                  n64_rvalid;
  logic [PIF_DATA_W-1:0] n64_rdata;
  logic                  cpu_req;
  logic                  cpu_wren;
  logic [PIF_ADDR_W-1:0] cpu_address;
  logic [PIF_DATA_W-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [PIF_DATA_W-1:0] cpu_rdata;
  logic [PIF_ADDR_W-1:0] ram_address;
  logic                  ram_wren;
  logic [PIF_DATA_W-1:0] ram_wdata;
  logic [PIF_DATA_W-1:0] ram_rdata;
  logic                  lock_timeout;

  modport slave (
    input  pif_disable, n64_req, n64_lock, n64_wren, n64_address, n64_wdata,
    input  cpu_req, cpu_wren, cpu_address, cpu_wdata, ram_rdata,
    output n64_gnt, n64_rvalid, n64_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    output ram_address, ram_wren, ram_wdata, lock_timeout
  );

  modport master (
    output pif_disable, n64_req, n64_lock, n64_wren, n64_address, n64_wdata,
    output cpu_req, cpu_wren, cpu_address, cpu_wdata, ram_rdata,
    input  n64_gnt, n64_rvalid, n64_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ram_address, ram_wren, ram_wdata, lock_timeout
  );

endinterface

// File: rtl/pif_rd_tag_pipe.sv
// Shift register of read owner tags. A tag pushed with a grant emerges on
// tag_o in the cycle the RAM returns that read's data.
module pif_rd_tag_pipe
  import pif_ram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_l,
  input  owner_tag_e tag_i,
  output owner_tag_e tag_o
);

  owner_tag_e pipe_q [DEPTH];

  // Advance tags one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= TAG_NONE;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pif_ram_arbiter.sv
// Arbitrates the single-port PIF RAM between the N64 serial interface and the
// local CPU: N64 has fixed priority, the CPU gets a forced slot after a run of
// N64 grants, and an N64 burst lock is bounded by a watchdog.
module pif_ram_arbiter
  import pif_ram_arb_pkg::*;
#(
  parameter int RAM_RD_LATENCY = 1,
  parameter int STARVE_LIMIT   = 4,
  parameter int BURST_MAX      = 600
) (
  input logic              clk,
  input logic              reset_l,
  pif_ram_arbiter_if.slave bus
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int BC_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  arb_state_e            state_q;
  logic [BC_W-1:0]       burst_q;
  logic [SC_W-1:0]       starve_q;
  logic [PIF_ADDR_W-1:0] ram_addr_q;
  logic                  ram_wren_q;
  logic [PIF_DATA_W-1:0] ram_wdata_q;

  logic       starve_hit, n64_ok, lock_hit, burst_hold;
  logic       n64_gnt, cpu_gnt;
  owner_tag_e push_tag, rd_tag;

  // Grant decision; lock_hit is the watchdog firing on a still-held lock.
  always_comb begin
    starve_hit = bus.cpu_req && (starve_q == SC_W'(STARVE_LIMIT));
    n64_ok     = bus.n64_req && !bus.pif_disable;
    lock_hit   = (state_q == BURST) && bus.n64_lock &&
                 (burst_q == BC_W'(BURST_MAX - 1));
    burst_hold = (state_q == BURST) && bus.n64_lock && !bus.pif_disable && !lock_hit;
    n64_gnt    = 1'b0;
    cpu_gnt    = 1'b0;
    if (reset_l) begin
      if (burst_hold)      n64_gnt = n64_ok;
      else if (starve_hit) cpu_gnt = 1'b1;
      else if (n64_ok)     n64_gnt = 1'b1;
      else                 cpu_gnt = bus.cpu_req;
    end
  end

  // Lock FSM: a lock is honoured from IDLE, held in BURST, refused in LOCK_ERR.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (n64_gnt && bus.n64_lock) begin
            state_q <= BURST;
            burst_q <= '0;
          end
        end
        BURST: begin
          if (lock_hit) begin
            state_q <= LOCK_ERR;
          end else if (burst_hold) begin
            burst_q <= burst_q + BC_W'(1);
          end else if (n64_gnt && bus.n64_lock) begin
            burst_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCK_ERR: begin
          if (!bus.n64_lock) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Count N64 wins over a waiting CPU; any CPU win or idle CPU clears it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      starve_q <= '0;
    end else if (cpu_gnt || !bus.cpu_req) begin
      starve_q <= '0;
    end else if (n64_gnt && (starve_q < SC_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + SC_W'(1);
    end
  end

  // Register the winner's access onto the RAM port; no grant means no write.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ram_addr_q  <= '0;
      ram_wren_q  <= 1'b0;
      ram_wdata_q <= '0;
    end else if (n64_gnt) begin
      ram_addr_q  <= bus.n64_address;
      ram_wren_q  <= bus.n64_wren;
      ram_wdata_q <= bus.n64_wdata;
    end else if (cpu_gnt) begin
      ram_addr_q  <= bus.cpu_address;
      ram_wren_q  <= bus.cpu_wren;
      ram_wdata_q <= bus.cpu_wdata;
    end else begin
      ram_wren_q  <= 1'b0;
    end
  end

  // Tag each granted read with its owner; writes and idle cycles carry NONE.
  always_comb begin
    push_tag = TAG_NONE;
    if (n64_gnt && !bus.n64_wren)      push_tag = TAG_N64;
    else if (cpu_gnt && !bus.cpu_wren) push_tag = TAG_CPU;
  end

  pif_rd_tag_pipe #(
    .DEPTH (RAM_RD_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_l (reset_l),
    .tag_i   (push_tag),
    .tag_o   (rd_tag)
  );

  assign bus.n64_gnt      = n64_gnt;
  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.lock_timeout = lock_hit;
  assign bus.ram_address  = ram_addr_q;
  assign bus.ram_wren     = ram_wren_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.n64_rvalid   = (rd_tag == TAG_N64);
  assign bus.cpu_rvalid   = (rd_tag == TAG_CPU);
  assign bus.n64_rdata    = (rd_tag == TAG_N64) ? bus.ram_rdata : '0;
  assign bus.cpu_rdata    = (rd_tag == TAG_CPU) ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Bench for pif_ram_arbiter: two instances (default watchdog and BURST_MAX=8)
// share one stimulus stream, each with its own RAM and reference model.
module tb_pif_ram_arbiter;
  import pif_ram_arb_pkg::*;

  localparam int SL = 4;
  localparam int M_FREE = 0, M_BURST = 1, M_ERR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l;
  logic        pif_disable, n64_req, n64_lock, n64_wren, cpu_req, cpu_wren;
  logic [8:0]  n64_address, cpu_address;
  logic [31:0] n64_wdata, cpu_wdata;

  pif_ram_arbiter_if bus0 ();
  pif_ram_arbiter_if bus1 ();

  pif_ram_arbiter #(.RAM_RD_LATENCY(1), .STARVE_LIMIT(SL), .BURST_MAX(600)) dut0 (
    .clk(clk), .reset_l(reset_l), .bus(bus0));
  pif_ram_arbiter #(.RAM_RD_LATENCY(1), .STARVE_LIMIT(SL), .BURST_MAX(8)) dut1 (
    .clk(clk), .reset_l(reset_l), .bus(bus1));

  // Synchronous read-first RAMs, one per instance.
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  always @(posedge clk) begin
    bus0.ram_rdata <= mem0[bus0.ram_address];
    if (bus0.ram_wren) mem0[bus0.ram_address] <= bus0.ram_wdata;
    bus1.ram_rdata <= mem1[bus1.ram_address];
    if (bus1.ram_wren) mem1[bus1.ram_address] <= bus1.ram_wdata;
  end

  // Reference model state.
  int          bmax      [2];
  int          m_state   [2];
  int          m_starve  [2];
  int          m_bcnt    [2];
  logic [8:0]  m_addr    [2];
  logic        m_wren    [2];
  logic [31:0] m_wdata   [2];
  int          sched_own [2][4];
  logic [31:0] sched_dat [2][4];
  logic [31:0] sh        [2][512];
  int          cyc;

  // Observed outputs, sampled at the falling edge.
  logic        o_n64g [2], o_cpug [2], o_lto [2], o_rw [2], o_nrv [2], o_crv [2];
  logic [8:0]  o_ra   [2];
  logic [31:0] o_rwd  [2], o_nrd [2], o_crd [2];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 ^ (a * 32'h0001_0203);
  endfunction

  task automatic apply();
    bus0.pif_disable = pif_disable; bus1.pif_disable = pif_disable;
    bus0.n64_req     = n64_req;     bus1.n64_req     = n64_req;
    bus0.n64_lock    = n64_lock;    bus1.n64_lock    = n64_lock;
    bus0.n64_wren    = n64_wren;    bus1.n64_wren    = n64_wren;
    bus0.n64_address = n64_address; bus1.n64_address = n64_address;
    bus0.n64_wdata   = n64_wdata;   bus1.n64_wdata   = n64_wdata;
    bus0.cpu_req     = cpu_req;     bus1.cpu_req     = cpu_req;
    bus0.cpu_wren    = cpu_wren;    bus1.cpu_wren    = cpu_wren;
    bus0.cpu_address = cpu_address; bus1.cpu_address = cpu_address;
    bus0.cpu_wdata   = cpu_wdata;   bus1.cpu_wdata   = cpu_wdata;
  endtask

  task automatic set_idle();
    pif_disable = 0; n64_req = 0; n64_lock = 0; n64_wren = 0; n64_address = '0;
    n64_wdata = '0; cpu_req = 0; cpu_wren = 0; cpu_address = '0; cpu_wdata = '0;
  endtask

  // One cycle of the model for instance i: check, arbitrate, update.
  task automatic model_step(input int i);
    int          slot, own, g, nslot;
    logic [8:0]  a;
    logic        w;
    logic [31:0] d;
    bit          starve_hit, n_ok, tmo, hold;
    string       p;
    p    = $sformatf("i%0d.", i);
    slot = cyc % 4;
    if (!reset_l) begin
      chk({p, "rst_n64_gnt"}, o_n64g[i], 0);
      chk({p, "rst_cpu_gnt"}, o_cpug[i], 0);
      chk({p, "rst_lock_timeout"}, o_lto[i], 0);
      chk({p, "rst_ram_address"}, o_ra[i], 0);
      chk({p, "rst_ram_wren"}, o_rw[i], 0);
      chk({p, "rst_ram_wdata"}, o_rwd[i], 0);
      chk({p, "rst_n64_rvalid"}, o_nrv[i], 0);
      chk({p, "rst_cpu_rvalid"}, o_crv[i], 0);
      chk({p, "rst_n64_rdata"}, o_nrd[i], 0);
      chk({p, "rst_cpu_rdata"}, o_crd[i], 0);
      m_state[i] = M_FREE; m_starve[i] = 0; m_bcnt[i] = 0;
      m_addr[i] = '0; m_wren[i] = 0; m_wdata[i] = '0;
      for (int k = 0; k < 4; k++) sched_own[i][k] = 0;
      return;
    end
    chk({p, "ram_address"}, o_ra[i], m_addr[i]);
    chk({p, "ram_wren"}, o_rw[i], m_wren[i]);
    chk({p, "ram_wdata"}, o_rwd[i], m_wdata[i]);
    own = sched_own[i][slot];
    chk({p, "n64_rvalid"}, o_nrv[i], own == 1);
    chk({p, "cpu_rvalid"}, o_crv[i], own == 2);
    chk({p, "n64_rdata"}, o_nrd[i], (own == 1) ? sched_dat[i][slot] : 32'h0);
    chk({p, "cpu_rdata"}, o_crd[i], (own == 2) ? sched_dat[i][slot] : 32'h0);
    sched_own[i][slot] = 0;

    starve_hit = cpu_req && (m_starve[i] == SL);
    n_ok       = n64_req && !pif_disable;
    tmo        = (m_state[i] == M_BURST) && n64_lock && (m_bcnt[i] == bmax[i] - 1);
    hold       = (m_state[i] == M_BURST) && n64_lock && !pif_disable && !tmo;
    if (hold)            g = n_ok ? 1 : 0;
    else if (starve_hit) g = 2;
    else if (n_ok)       g = 1;
    else if (cpu_req)    g = 2;
    else                 g = 0;
    chk({p, "n64_gnt"}, o_n64g[i], g == 1);
    chk({p, "cpu_gnt"}, o_cpug[i], g == 2);
    chk({p, "lock_timeout"}, o_lto[i], tmo);

    if (g == 1) begin a = n64_address; w = n64_wren; d = n64_wdata; end
    else        begin a = cpu_address; w = cpu_wren; d = cpu_wdata; end
    if (g != 0) begin
      m_addr[i] = a; m_wren[i] = w; m_wdata[i] = d;
      if (w) sh[i][a] = d;
      else begin
        nslot = (cyc + 2) % 4;
        sched_own[i][nslot] = g;
        sched_dat[i][nslot] = sh[i][a];
      end
    end else begin
      m_wren[i] = 0;
    end

    if (tmo)                         m_state[i] = M_ERR;
    else if (hold)                   m_bcnt[i]++;
    else if (m_state[i] == M_ERR)    m_state[i] = n64_lock ? M_ERR : M_FREE;
    else if (g == 1 && n64_lock) begin m_state[i] = M_BURST; m_bcnt[i] = 0; end
    else                             m_state[i] = M_FREE;

    if (g == 2 || !cpu_req)             m_starve[i] = 0;
    else if (g == 1 && m_starve[i] < SL) m_starve[i]++;
  endtask

  task automatic tick();
    apply();
    @(negedge clk);
    o_n64g[0] = bus0.n64_gnt;     o_n64g[1] = bus1.n64_gnt;
    o_cpug[0] = bus0.cpu_gnt;     o_cpug[1] = bus1.cpu_gnt;
    o_lto[0]  = bus0.lock_timeout; o_lto[1] = bus1.lock_timeout;
    o_ra[0]   = bus0.ram_address; o_ra[1]   = bus1.ram_address;
    o_rw[0]   = bus0.ram_wren;    o_rw[1]   = bus1.ram_wren;
    o_rwd[0]  = bus0.ram_wdata;   o_rwd[1]  = bus1.ram_wdata;
    o_nrv[0]  = bus0.n64_rvalid;  o_nrv[1]  = bus1.n64_rvalid;
    o_nrd[0]  = bus0.n64_rdata;   o_nrd[1]  = bus1.n64_rdata;
    o_crv[0]  = bus0.cpu_rvalid;  o_crv[1]  = bus1.cpu_rvalid;
    o_crd[0]  = bus0.cpu_rdata;   o_crd[1]  = bus1.cpu_rdata;
    for (int i = 0; i < 2; i++) model_step(i);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    int n_cnt, c_cnt, t_idx, c_idx, lto_cnt;
    bit crv_seen, lock_r;

    bmax[0] = 600; bmax[1] = 8; cyc = 0;
    for (int a = 0; a < 512; a++) begin
      mem0[a] = init_word(a); mem1[a] = init_word(a);
      sh[0][a] = init_word(a); sh[1][a] = init_word(a);
    end
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) sched_own[i][k] = 0;
    bus0.ram_rdata = '0; bus1.ram_rdata = '0;
    set_idle();
    reset_l = 0;
    apply();
    @(posedge clk); #1;
    repeat (3) tick();
    reset_l = 1;
    tick();

    // Single N64 read of a word preloaded through a write.
    n64_req = 1; n64_wren = 1; n64_address = 9'h1F0; n64_wdata = 32'hDEADBEEF;
    tick();
    set_idle(); tick();
    n64_req = 1; n64_address = 9'h1F0;
    tick();
    chk("rd_gnt", o_n64g[0], 1);
    crv_seen = o_crv[0];
    set_idle(); tick();
    chk("rd_addr", o_ra[0], 9'h1F0);
    crv_seen |= o_crv[0];
    tick();
    chk("rd_valid", o_nrv[0], 1);
    chk("rd_data", o_nrd[0], 32'hDEADBEEF);
    crv_seen |= o_crv[0];
    chk("rd_no_cpu_rvalid", crv_seen, 0);
    tick();

    // Starvation escape: both requesting continuously.
    n64_req = 1; n64_address = 9'h010; cpu_req = 1; cpu_address = 9'h020;
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      pat = {pat[8:0], o_cpug[0]};
    end
    chk("starve_pattern", pat, 10'b0000100001);
    set_idle(); repeat (3) tick();

    // 16-word locked burst with the CPU waiting.
    n_cnt = 0; c_cnt = 0;
    n64_req = 1; n64_lock = 1; cpu_req = 1; cpu_address = 9'h033;
    for (int k = 0; k < 16; k++) begin
      n64_address = 9'(k);
      tick();
      n_cnt += int'(o_n64g[0]);
      c_cnt += int'(o_cpug[0]);
    end
    chk("burst_n64_grants", n_cnt, 16);
    chk("burst_cpu_grants", c_cnt, 0);
    n64_req = 0; n64_lock = 0;
    tick();
    chk("burst_release_cpu", o_cpug[0], 1);
    set_idle(); repeat (3) tick();

    // Watchdog on the BURST_MAX=8 instance.
    t_idx = -1; c_idx = -1; lto_cnt = 0;
    n64_req = 1; n64_lock = 1; cpu_req = 1; cpu_address = 9'h044;
    for (int k = 0; k < 20; k++) begin
      n64_address = 9'(9'h100 + k);
      tick();
      if (o_lto[1]) begin lto_cnt++; if (t_idx < 0) t_idx = k; end
      if (t_idx >= 0 && c_idx < 0 && o_cpug[1]) c_idx = k;
    end
    chk("wd_pulse_cycle", t_idx, 8);
    chk("wd_pulse_count", lto_cnt, 1);
    chk("wd_cpu_within5", (c_idx >= t_idx) && (c_idx - t_idx <= 5), 1);
    n64_lock = 0; tick();
    n64_lock = 1; repeat (4) tick();
    set_idle(); repeat (3) tick();

    // pif_disable raised in the middle of a burst.
    n64_req = 1; n64_lock = 1; cpu_req = 1; cpu_address = 9'h055;
    repeat (3) tick();
    pif_disable = 1;
    tick();
    chk("dis_no_n64_gnt", o_n64g[0], 0);
    chk("dis_cpu_gnt", o_cpug[0], 1);
    pif_disable = 0; n64_req = 0;
    tick();
    chk("dis_back_idle", o_cpug[0], 1);
    set_idle(); repeat (3) tick();

    // Reset one cycle after a CPU read grant.
    cpu_req = 1; cpu_address = 9'h077;
    tick();
    chk("rst_rd_gnt", o_cpug[0], 1);
    cpu_req = 0; n64_req = 1; reset_l = 0;
    tick();
    chk("rst_gnt_blocked", o_n64g[0], 0);
    chk("rst_addr_cleared", o_ra[0], 0);
    reset_l = 1; n64_req = 0;
    tick();
    chk("rst_no_cpu_rvalid", o_crv[0], 0);
    tick();

    // Randomized traffic against the model.
    lock_r = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) lock_r = ~lock_r;
      pif_disable = ($urandom_range(0, 15) == 0);
      n64_req     = ($urandom_range(0, 9) < 6);
      n64_lock    = lock_r;
      n64_wren    = $urandom_range(0, 1) == 1;
      n64_address = 9'($urandom_range(0, 15));
      n64_wdata   = $urandom;
      cpu_req     = ($urandom_range(0, 9) < 5);
      cpu_wren    = $urandom_range(0, 1) == 1;
      cpu_address = 9'($urandom_range(0, 15));
      cpu_wdata   = $urandom;
      tick();
    end
    set_idle(); repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
